// File: rtl/exec_if.sv
// Handshake bundle between decode, the execute stage and writeback/memory.
//   in_valid/in_ready  : instruction offer/accept (opcode, a, b, imm)
//   out_valid/out_ready: registered result offer/accept (result, flags)
//   busy               : iterative divider is running
// master = upstream/downstream side (the bench or pipeline), slave = exec_unit.
interface exec_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        opcode;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] imm;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic [1:0]        flags;
   logic              busy;

   modport master (
      output in_valid, opcode, a, b, imm, out_ready,
      input  in_ready, out_valid, result, flags, busy
   );

   modport slave (
      input  in_valid, opcode, a, b, imm, out_ready,
      output in_ready, out_valid, result, flags, busy
   );
endinterface

// File: rtl/exec_unit.sv
// Handshaked execute stage: operand steering, ALU, iterative radix-2 divider.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (aborts any divide in flight)
//   bus  - exec_if.slave: in_valid/in_ready/opcode/a/b/imm in,
//          out_valid/out_ready/result/flags out, busy while dividing.
// Results and flags ([1]=Z, [0]=N) are registered; single-cycle ops have
// latency 1, DIV with a nonzero divisor takes DATA_W steps.
module exec_unit #(
   parameter int DATA_W = 32,
   parameter int DIV_EN = 1
) (
   input logic   clk,
   input logic   rst,
   exec_if.slave bus
);
   localparam bit HAS_DIV = (DIV_EN != 0);
   localparam int CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00100;
   localparam logic [4:0] OP_SUBI  = 5'b00101;
   localparam logic [4:0] OP_MUL   = 5'b00110;
   localparam logic [4:0] OP_MOVEH = 5'b00111;
   localparam logic [4:0] OP_DIV   = 5'b01000;
   localparam logic [4:0] OP_AND   = 5'b01010;
   localparam logic [4:0] OP_ANDI  = 5'b01011;
   localparam logic [4:0] OP_OR    = 5'b01100;
   localparam logic [4:0] OP_ORI   = 5'b01101;
   localparam logic [4:0] OP_NOT   = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b10000;
   localparam logic [4:0] OP_XORI  = 5'b10001;
   localparam logic [4:0] OP_CMP   = 5'b10010;
   localparam logic [4:0] OP_ST    = 5'b11100;
   localparam logic [4:0] OP_LD    = 5'b11101;
   localparam logic [4:0] OP_MOVEL = 5'b11110;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIV_RUN = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   function automatic logic [1:0] flags_of(input logic [DATA_W-1:0] v);
      return {(v == '0), v[DATA_W-1]};
   endfunction

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] result_reg, result_next;
   logic [1:0]        flags_reg, flags_next;
   logic [DATA_W-1:0] rem_reg, rem_next;
   logic [DATA_W-1:0] quot_reg, quot_next;      // dividend shifts out, quotient shifts in
   logic [DATA_W-1:0] divisor_reg, divisor_next;
   logic [CNT_W-1:0]  count_reg, count_next;

   logic [DATA_W-1:0] low_mask;
   logic [DATA_W-1:0] op_a, op_b;
   logic [DATA_W-1:0] alu_res;
   logic              in_ready;
   logic              accept;
   logic              div_start;

   logic [DATA_W:0]   rem_shift;
   logic [DATA_W:0]   rem_diff;
   logic              q_bit;
   logic [DATA_W-1:0] quot_step;

   // Lower half set, upper half clear; MOVEH uses the complement.
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
         assign low_mask[gi] = (gi < DATA_W / 2);
      end
   endgenerate

   // Operand steering
   always_comb begin
      op_a = bus.a;
      op_b = bus.b;
      case (bus.opcode)
         OP_ST: begin
            op_a = bus.b;
            op_b = bus.imm;
         end
         OP_LD, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: op_b = bus.imm;
         OP_MOVEL: begin
            op_a = bus.imm;
            op_b = low_mask;
         end
         OP_MOVEH: begin
            op_a = bus.imm;
            op_b = ~low_mask;
         end
         default: ;
      endcase
   end

   // Single-cycle ALU; DIV here only covers the non-iterating cases.
   always_comb begin
      alu_res = op_a;
      case (bus.opcode)
         OP_ADD, OP_ADDI, OP_LD, OP_ST:        alu_res = op_a + op_b;
         OP_SUB, OP_SUBI, OP_CMP:              alu_res = op_a - op_b;
         OP_MUL:                               alu_res = op_a * op_b;
         OP_DIV:                               alu_res = '1;
         OP_AND, OP_ANDI, OP_MOVEL, OP_MOVEH:  alu_res = op_a & op_b;
         OP_OR, OP_ORI:                        alu_res = op_a | op_b;
         OP_XOR, OP_XORI:                      alu_res = op_a ^ op_b;
         OP_NOT:                               alu_res = ~op_a;
         default: ;
      endcase
   end

   assign div_start = HAS_DIV && (bus.opcode == OP_DIV) && (op_b != '0);

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift = {rem_reg, quot_reg[DATA_W-1]};
   assign rem_diff  = rem_shift - {1'b0, divisor_reg};
   assign q_bit     = ~rem_diff[DATA_W];
   assign quot_step = {quot_reg[DATA_W-2:0], q_bit};

   // A held result blocks new work unless it is being consumed this cycle.
   assign in_ready = (state_reg == S_IDLE) ||
                     ((state_reg == S_HOLD) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_next   = state_reg;
      result_next  = result_reg;
      flags_next   = flags_reg;
      rem_next     = rem_reg;
      quot_next    = quot_reg;
      divisor_next = divisor_reg;
      count_next   = count_reg;
      case (state_reg)
         S_IDLE, S_HOLD: begin
            if ((state_reg == S_HOLD) && bus.out_ready) begin
               state_next = S_IDLE;
            end
            if (accept) begin
               if (div_start) begin
                  state_next   = S_DIV_RUN;
                  rem_next     = '0;
                  quot_next    = op_a;
                  divisor_next = op_b;
                  count_next   = '0;
               end else begin
                  state_next  = S_HOLD;
                  result_next = alu_res;
                  flags_next  = flags_of(alu_res);
               end
            end
         end
         S_DIV_RUN: begin
            rem_next   = q_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            quot_next  = quot_step;
            count_next = count_reg + CNT_W'(1);
            if (count_reg == LAST_STEP) begin
               state_next  = S_HOLD;
               result_next = quot_step;
               flags_next  = flags_of(quot_step);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         result_reg  <= '0;
         flags_reg   <= '0;
         rem_reg     <= '0;
         quot_reg    <= '0;
         divisor_reg <= '0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         result_reg  <= result_next;
         flags_reg   <= flags_next;
         rem_reg     <= rem_next;
         quot_reg    <= quot_next;
         divisor_reg <= divisor_next;
         count_reg   <= count_next;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_reg == S_HOLD);
   assign bus.busy      = (state_reg == S_DIV_RUN);
   assign bus.result    = result_reg;
   assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a 32-bit instance with the divider and a
// 16-bit instance without it. Expected results are queued at issue and
// compared when the unit hands a result over.
module tb_exec_unit;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00100;
   localparam logic [4:0] OP_SUBI  = 5'b00101;
   localparam logic [4:0] OP_MUL   = 5'b00110;
   localparam logic [4:0] OP_MOVEH = 5'b00111;
   localparam logic [4:0] OP_DIV   = 5'b01000;
   localparam logic [4:0] OP_OR    = 5'b01100;
   localparam logic [4:0] OP_NOT   = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b10000;
   localparam logic [4:0] OP_CMP   = 5'b10010;
   localparam logic [4:0] OP_CALL  = 5'b11000;
   localparam logic [4:0] OP_ST    = 5'b11100;
   localparam logic [4:0] OP_MOVEL = 5'b11110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [33:0] q32[$];
   logic [17:0] q16[$];

   exec_if #(.DATA_W(32)) b32 ();
   exec_if #(.DATA_W(16)) b16 ();

   exec_unit #(.DATA_W(32), .DIV_EN(1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   exec_unit #(.DATA_W(16), .DIV_EN(0)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: one pop per completed output handshake.
   always @(negedge clk) begin
      if (!rst && b32.out_valid === 1'b1 && b32.out_ready === 1'b1) begin
         if (q32.size() == 0) begin
            chk("unexpected_out32", {30'd0, b32.flags, b32.result}, 64'hDEAD);
         end else begin
            logic [33:0] e;
            e = q32.pop_front();
            $display("txn32 result=%h flags=%b exp_result=%h exp_flags=%b",
                     b32.result, b32.flags, e[31:0], e[33:32]);
            chk("sb32_result", b32.result, e[31:0]);
            chk("sb32_flags", b32.flags, e[33:32]);
         end
      end
      if (!rst && b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
         if (q16.size() == 0) begin
            chk("unexpected_out16", {46'd0, b16.flags, b16.result}, 64'hDEAD);
         end else begin
            logic [17:0] e;
            e = q16.pop_front();
            $display("txn16 result=%h flags=%b exp_result=%h exp_flags=%b",
                     b16.result, b16.flags, e[15:0], e[17:16]);
            chk("sb16_result", b16.result, e[15:0]);
            chk("sb16_flags", b16.flags, e[17:16]);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue32(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] iv, input logic [31:0] er, input logic [1:0] ef,
                          input bit push);
      int waited;
      waited = 0;
      b32.opcode = op; b32.a = av; b32.b = bv; b32.imm = iv; b32.in_valid = 1'b1;
      if (push) q32.push_back({ef, er});
      @(negedge clk);
      while (b32.in_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("accept32_wait_ok", (waited < 100), 1);
      @(posedge clk);
      #1;
      b32.in_valid = 1'b0;
   endtask

   task automatic issue16(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] iv, input logic [15:0] er, input logic [1:0] ef);
      int waited;
      waited = 0;
      b16.opcode = op; b16.a = av; b16.b = bv; b16.imm = iv; b16.in_valid = 1'b1;
      q16.push_back({ef, er});
      @(negedge clk);
      while (b16.in_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("accept16_wait_ok", (waited < 100), 1);
      @(posedge clk);
      #1;
      b16.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy_cnt;
      int ready_bad;
      int waited;

      b32.in_valid = 1'b0; b32.opcode = '0; b32.a = '0; b32.b = '0; b32.imm = '0; b32.out_ready = 1'b1;
      b16.in_valid = 1'b0; b16.opcode = '0; b16.a = '0; b16.b = '0; b16.imm = '0; b16.out_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_out_valid", b32.out_valid, 0);
      chk("rst_result", b32.result, 0);
      chk("rst_flags", b32.flags, 0);
      chk("rst_busy", b32.busy, 0);
      chk("rst_in_ready", b32.in_ready, 1);
      chk("rst16_result", b16.result, 0);

      // ADD with latency 1, then out_valid drops
      issue32(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 2'b00, 1'b1);
      chk("add_latency_valid", b32.out_valid, 1);
      chk("add_result", b32.result, 12);
      tick();
      chk("add_valid_drop", b32.out_valid, 0);

      // Operand steering and ALU ops
      issue32(OP_SUB,   32'd3, 32'd3, 32'd0, 32'd0, 2'b10, 1'b1);
      issue32(OP_SUBI,  32'd1, 32'd9, 32'd2, 32'hFFFF_FFFF, 2'b01, 1'b1);
      issue32(OP_MOVEH, 32'd1, 32'd2, 32'h1234_5678, 32'h1234_0000, 2'b00, 1'b1);
      issue32(OP_MOVEL, 32'd1, 32'd2, 32'h1234_5678, 32'h0000_5678, 2'b00, 1'b1);
      issue32(OP_ST,    32'h55, 32'h100, 32'd4, 32'h104, 2'b00, 1'b1);
      issue32(OP_MUL,   32'd6, 32'd7, 32'd0, 32'd42, 2'b00, 1'b1);
      issue32(OP_NOT,   32'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2'b01, 1'b1);
      issue32(OP_CMP,   32'd2, 32'd5, 32'd0, 32'hFFFF_FFFD, 2'b01, 1'b1);
      issue32(OP_OR,    32'hA0, 32'h0B, 32'd0, 32'hAB, 2'b00, 1'b1);
      issue32(OP_CALL,  32'h8000_0001, 32'd3, 32'd4, 32'h8000_0001, 2'b01, 1'b1);
      tick();

      // Iterative DIV: inputs change after accept and must be ignored
      issue32(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd14, 2'b00, 1'b1);
      b32.a = 32'hFFFF; b32.b = 32'd1;
      busy_cnt = 0;
      ready_bad = 0;
      @(negedge clk);
      while (b32.busy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         if (b32.in_ready !== 1'b0) ready_bad++;
         @(negedge clk);
      end
      chk("div_busy_cycles", busy_cnt, 32);
      chk("div_in_ready_low", ready_bad, 0);
      chk("div_out_valid", b32.out_valid, 1);
      chk("div_result", b32.result, 14);
      tick();

      // DIV by zero: all-ones, latency 1, no iteration
      issue32(OP_DIV, 32'd55, 32'd0, 32'd0, 32'hFFFF_FFFF, 2'b01, 1'b1);
      chk("div0_valid", b32.out_valid, 1);
      chk("div0_busy", b32.busy, 0);
      chk("div0_result", b32.result, 32'hFFFF_FFFF);
      tick();

      // Backpressure with a queued XOR
      b32.out_ready = 1'b0;
      issue32(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 2'b00, 1'b1);
      b32.opcode = OP_XOR; b32.a = 32'hF0; b32.b = 32'hFF; b32.in_valid = 1'b1;
      q32.push_back({2'b00, 32'h0F});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", b32.out_valid, 1);
         chk("hold_result", b32.result, 2);
         chk("hold_in_ready", b32.in_ready, 0);
      end
      tick();
      b32.out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", b32.in_ready, 1);
      tick();
      b32.in_valid = 1'b0;
      chk("xor_valid", b32.out_valid, 1);
      chk("xor_result", b32.result, 32'h0F);

      // Back-to-back ADDI, no bubbles
      for (int i = 0; i < 8; i++) begin
         b32.opcode = OP_ADDI; b32.a = 32'(i * 3); b32.b = 32'd99; b32.imm = 32'h100;
         b32.in_valid = 1'b1;
         q32.push_back({2'b00, 32'(i * 3 + 32'h100)});
         @(negedge clk);
         chk("b2b_in_ready", b32.in_ready, 1);
         if (i > 0) chk("b2b_out_valid", b32.out_valid, 1);
         tick();
      end
      b32.in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_last_valid", b32.out_valid, 1);
      tick();
      @(negedge clk);
      chk("b2b_drained", b32.out_valid, 0);
      tick();

      // Reset in the middle of a DIV discards it
      issue32(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 2'b00, 1'b0);
      repeat (9) tick();
      chk("mid_div_busy", b32.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", b32.out_valid, 0);
      chk("abort_busy", b32.busy, 0);
      chk("abort_in_ready", b32.in_ready, 1);
      issue32(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd4, 2'b00, 1'b1);
      chk("post_abort_result", b32.result, 4);
      tick();

      // 16-bit instance, divider absent
      issue16(OP_MOVEH, 16'd1, 16'd2, 16'hABCD, 16'hAB00, 2'b01);
      chk("w16_moveh", b16.result, 16'hAB00);
      issue16(OP_MOVEL, 16'd1, 16'd2, 16'hABCD, 16'h00CD, 2'b00);
      issue16(OP_DIV, 16'd100, 16'd7, 16'd0, 16'hFFFF, 2'b01);
      chk("w16_div_valid", b16.out_valid, 1);
      chk("w16_div_busy", b16.busy, 0);
      issue16(OP_ADD, 16'h8000, 16'h8000, 16'd0, 16'h0000, 2'b10);
      tick();

      // Every queued expectation must have been consumed
      waited = 0;
      while ((q32.size() != 0 || q16.size() != 0) && waited < 50) begin
         tick();
         waited++;
      end
      chk("q32_empty", q32.size(), 0);
      chk("q16_empty", q16.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
